// File: rtl/adc_meter_pkg.sv
// ============================================================================
// Module : adc_meter_pkg
// Brief  : Shared state encoding and default constants for the ADC meter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package adc_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam int DEF_DATA_W      = 12;
  localparam int DEF_MID         = 2048;
  localparam int DEF_HYST        = 64;
  localparam int DEF_GATE_CYCLES = 50_000_000;

endpackage

`default_nettype wire

// File: rtl/adc_hyst_cmp.sv
// ============================================================================
// Module : adc_hyst_cmp
// Brief  : Mid-scale comparator with hysteresis and a rising-crossing pulse.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module adc_hyst_cmp #(
  parameter int DATA_W = 12,
  parameter int MID    = 2048,
  parameter int HYST   = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] sample,
  input  logic              init_load,
  input  logic              init_level,
  output logic              level,
  output logic              rise
);

  localparam logic [DATA_W-1:0] HI = DATA_W'(MID + HYST);
  localparam logic [DATA_W-1:0] LO = DATA_W'(MID - HYST);

  logic above_hi;
  logic below_lo;

  assign above_hi = (sample > HI);
  assign below_lo = (sample < LO);

  // A load cycle re-seeds the level, so it must never report an edge.
  assign rise = !init_load && !level && above_hi;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level <= 1'b0;
    end else if (init_load) begin
      level <= init_level;
    end else if (above_hi) begin
      level <= 1'b1;
    end else if (below_lo) begin
      level <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/adc_freq_meter.sv
// ============================================================================
// Module : adc_freq_meter
// Brief  : Gated frequency counter and min/max/peak-to-peak tracker for a
//          parallel offset-binary ADC clocked from this block.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module adc_freq_meter
  import adc_meter_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int GATE_CYCLES = DEF_GATE_CYCLES,
  parameter int MID         = DEF_MID,
  parameter int HYST        = DEF_HYST
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [DATA_W-1:0] ADC_Data,
  output logic              ADC_CLK,
  input  logic              Start,
  output logic              Busy,
  output logic              Done,
  output logic [31:0]       Freq_cnt,
  output logic [DATA_W-1:0] Vmax,
  output logic [DATA_W-1:0] Vmin,
  output logic [DATA_W-1:0] Vpp
);

  localparam logic [31:0]       GATE_LAST = 32'(GATE_CYCLES - 1);
  localparam logic [DATA_W-1:0] MID_VAL   = DATA_W'(MID);

  // ADC latches on our falling edge, so its outputs are stable at our rising edge.
  assign ADC_CLK = ~Clk;

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] s1;
  logic [DATA_W-1:0] s2;
  logic [31:0]       gate_cnt;
  logic [31:0]       edge_cnt;
  logic [DATA_W-1:0] max_trk;
  logic [DATA_W-1:0] min_trk;
  logic [31:0]       edge_nxt;
  logic [DATA_W-1:0] max_nxt;
  logic [DATA_W-1:0] min_nxt;
  logic              start_meas;
  logic              gate_last;
  logic              level;
  logic              rise;

  assign start_meas = (state == IDLE) && Start;
  assign gate_last  = (state == MEASURE) && (gate_cnt == GATE_LAST);

  adc_hyst_cmp #(
    .DATA_W (DATA_W),
    .MID    (MID),
    .HYST   (HYST)
  ) u_hyst (
    .clk        (Clk),
    .rst_n      (Reset_n),
    .sample     (s2),
    .init_load  (start_meas),
    .init_level (s2 >= MID_VAL),
    .level      (level),
    .rise       (rise)
  );

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Start) state_nxt = MEASURE;
      MEASURE: if (gate_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    Busy = (state == MEASURE);
    Done = (state == DONE);
  end

  // Next-tracker values let the final gate sample land in the published result.
  assign edge_nxt = (rise && (edge_cnt != 32'hFFFF_FFFF)) ? edge_cnt + 32'd1 : edge_cnt;
  assign max_nxt  = (s2 > max_trk) ? s2 : max_trk;
  assign min_nxt  = (s2 < min_trk) ? s2 : min_trk;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      s1       <= '0;
      s2       <= '0;
      gate_cnt <= '0;
      edge_cnt <= '0;
      max_trk  <= '0;
      min_trk  <= '0;
      Freq_cnt <= '0;
      Vmax     <= '0;
      Vmin     <= '0;
      Vpp      <= '0;
    end else begin
      s1 <= ADC_Data;
      s2 <= s1;
      if (start_meas) begin
        gate_cnt <= '0;
        edge_cnt <= '0;
        max_trk  <= '0;
        min_trk  <= '1;
      end else if (state == MEASURE) begin
        gate_cnt <= gate_cnt + 32'd1;
        edge_cnt <= edge_nxt;
        max_trk  <= max_nxt;
        min_trk  <= min_nxt;
      end
      if (gate_last) begin
        Freq_cnt <= edge_nxt;
        Vmax     <= max_nxt;
        Vmin     <= min_nxt;
        Vpp      <= max_nxt - min_nxt;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_adc_freq_meter.sv
// ============================================================================
// Module : tb_adc_freq_meter
// Brief  : Self-checking bench for adc_freq_meter against a sample-history model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_adc_freq_meter;

  localparam int DW   = 12;
  localparam int G    = 1000;
  localparam int MIDV = 2048;
  localparam int HYS  = 64;

  logic          Clk;
  logic          Reset_n;
  logic [DW-1:0] ADC_Data;
  logic          ADC_CLK;
  logic          Start;
  logic          Busy;
  logic          Done;
  logic [31:0]   Freq_cnt;
  logic [DW-1:0] Vmax;
  logic [DW-1:0] Vmin;
  logic [DW-1:0] Vpp;

  int vectors = 0;
  int errors  = 0;
  int d[$];  // value presented on ADC_Data in each cycle, indexed by cycle

  adc_freq_meter #(
    .DATA_W      (DW),
    .GATE_CYCLES (G),
    .MID         (MIDV),
    .HYST        (HYS)
  ) dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .ADC_Data (ADC_Data),
    .ADC_CLK  (ADC_CLK),
    .Start    (Start),
    .Busy     (Busy),
    .Done     (Done),
    .Freq_cnt (Freq_cnt),
    .Vmax     (Vmax),
    .Vmin     (Vmin),
    .Vpp      (Vpp)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Present inputs for one cycle, then settle 1 time unit past the edge.
  task automatic drive(input int v, input logic st);
    ADC_Data = v[DW-1:0];
    Start    = st;
    d.push_back(v);
    @(posedge Clk);
    #1;
  endtask

  function automatic int gen(input int mode, input int k, input int ks, input int ph);
    int rel;
    rel = k - ks;
    case (mode)
      0: gen = (((k + ph) / 50) % 2 == 1) ? 3000 : 1000;
      1: gen = 2100;
      2: begin
        if (k % 2 == 1) gen = (k % 7 == 0) ? 4095 : 4095 - int'($urandom_range(0, 50));
        else            gen = (k % 7 == 0) ? 0    : int'($urandom_range(0, 50));
      end
      3: gen = (rel >= 500 && rel < 600) ? 100 : 4000;
      default: gen = int'($urandom_range(0, 4095));
    endcase
  endfunction

  // Reference: s2 during cycle c equals d[c-2]; Start in cycle ks gives a gate
  // over cycles ks+1..ks+G with the level seeded from the sample seen at ks.
  task automatic model(input int ks, output int cnt, output int mx, output int mn);
    bit lvl;
    int v;
    lvl = (d[ks-2] >= MIDV);
    cnt = 0;
    mx  = 0;
    mn  = (1 << DW) - 1;
    for (int j = 1; j <= G; j++) begin
      v = d[ks + j - 2];
      if (!lvl && v > MIDV + HYS) begin
        cnt++;
        lvl = 1'b1;
      end else if (lvl && v < MIDV - HYS) begin
        lvl = 1'b0;
      end
      if (v > mx) mx = v;
      if (v < mn) mn = v;
    end
  endtask

  task automatic run_meas(input string nm, input int mode, input int ph,
                          input int pre, input int restart_at);
    int ks, cnt, mx, mn, bad_cyc;
    bad_cyc = -1;
    for (int i = 0; i < pre; i++) drive(gen(mode, d.size(), d.size() + pre - i, ph), 1'b0);
    ks = d.size();
    drive(gen(mode, ks, ks, ph), 1'b1);
    for (int j = 1; j <= G; j++) begin
      if ((Busy !== 1'b1 || Done !== 1'b0) && bad_cyc < 0) bad_cyc = j;
      drive(gen(mode, ks + j, ks, ph), (j == restart_at));
    end
    model(ks, cnt, mx, mn);
    vectors++;
    if (bad_cyc >= 0) begin
      errors++;
      $display("FAIL %s busy_window: cycle %0d busy=%b done=%b, required busy=1 done=0", nm, bad_cyc, Busy, Done);
    end
    vectors++;
    if (Done !== 1'b1 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL %s done_latency: done=%b busy=%b at start+%0d, required done=1 busy=0", nm, Done, Busy, G + 1);
    end
    vectors++;
    if (Freq_cnt !== 32'(cnt)) begin
      errors++;
      $display("FAIL %s freq_cnt: got %0d required %0d", nm, Freq_cnt, cnt);
    end
    vectors++;
    if (Vmax !== DW'(mx)) begin
      errors++;
      $display("FAIL %s vmax: got %0d required %0d", nm, Vmax, mx);
    end
    vectors++;
    if (Vmin !== DW'(mn)) begin
      errors++;
      $display("FAIL %s vmin: got %0d required %0d", nm, Vmin, mn);
    end
    vectors++;
    if (Vpp !== DW'(mx - mn)) begin
      errors++;
      $display("FAIL %s vpp: got %0d required %0d", nm, Vpp, mx - mn);
    end
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    for (int i = 0; i < 3; i++) drive(int'($urandom_range(0, 4095)), 1'b1);
    vectors++;
    if ({Busy, Done} !== 2'b00 || Freq_cnt !== 32'd0 || Vmax !== '0 || Vmin !== '0 || Vpp !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b f=%0d max=%0d min=%0d vpp=%0d, required all 0",
               Busy, Done, Freq_cnt, Vmax, Vmin, Vpp);
    end
    vectors++;
    if (ADC_CLK !== ~Clk) begin
      errors++;
      $display("FAIL adc_clk_phase: got %b required %b", ADC_CLK, ~Clk);
    end
    Reset_n = 1'b1;
    drive(2000, 1'b0);
    vectors++;
    if (Busy !== 1'b0 || Done !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b done=%b required 0 0", Busy, Done);
    end
  endtask

  task automatic test_back_to_back();
    // Start at measurement cycle 300 must be ignored; Start right after Done begins anew.
    run_meas("restart_first", 0, 17, 4, 300);
    run_meas("restart_second", 4, 0, 1, 0);
  endtask

  task automatic test_reset_abort();
    int ks, done_seen;
    done_seen = 0;
    for (int i = 0; i < 4; i++) drive(1000, 1'b0);
    ks = d.size();
    drive(3000, 1'b1);
    for (int j = 1; j < 400; j++) drive(((j / 20) % 2 == 1) ? 3000 : 1000, 1'b0);
    Reset_n = 1'b0;
    drive(3000, 1'b0);
    Reset_n = 1'b1;
    vectors++;
    if (Busy !== 1'b0 || Done !== 1'b0 || Freq_cnt !== 32'd0 || Vmax !== '0 || Vmin !== '0 || Vpp !== '0) begin
      errors++;
      $display("FAIL abort_outputs: busy=%b done=%b f=%0d max=%0d min=%0d vpp=%0d, required all 0",
               Busy, Done, Freq_cnt, Vmax, Vmin, Vpp);
    end
    for (int j = 0; j < G; j++) begin
      if (Done === 1'b1 || Busy === 1'b1) done_seen++;
      drive(((j / 20) % 2 == 1) ? 3000 : 1000, 1'b0);
    end
    vectors++;
    if (done_seen != 0) begin
      errors++;
      $display("FAIL abort_no_done: %0d busy/done cycles seen, required 0 (start was %0d)", done_seen, ks);
    end
    run_meas("after_abort", 0, 5, 4, 0);
  endtask

  initial begin
    ADC_Data = '0;
    Start    = 1'b0;
    Reset_n  = 1'b0;
    test_reset();
    run_meas("square_1000_3000", 0, int'($urandom_range(0, 99)), 4, 0);
    run_meas("constant_2100", 1, 0, 4, 0);
    run_meas("fullscale_noisy", 2, 0, 4, 0);
    run_meas("initial_level_step", 3, 0, 4, 0);
    test_back_to_back();
    test_reset_abort();
    for (int r = 0; r < 2; r++) run_meas("random_samples", 4, 0, 3, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/adc_freq_meter.md
Name: adc_freq_meter

Overview:
- Receive-side counterpart of the dual-channel DDS/DAC output path.
- Captures samples from a parallel 12-bit offset-binary ADC (AD9226-class) that is clocked from this block.
- Over a fixed gate window, measures signal frequency by counting hysteresis-qualified rising crossings of mid-scale, and tracks min, max and peak-to-peak amplitude.
- Sits beside the DDS top level so a DAC channel looped back to the ADC can be checked on the board.

Parameters:
DATA_W, 12, ADC sample width (unsigned, offset binary)
GATE_CYCLES, 50_000_000, gate length in Clk cycles (1 s at 50 MHz, so Freq_cnt reads directly in Hz)
MID, 2048, mid-scale threshold
HYST, 64, hysteresis half-band; must satisfy HYST < MID

Ports:
Clk  input  1  system clock, 50 MHz
Reset_n  input  1  synchronous active-low reset
ADC_Data  input  DATA_W  raw ADC output bus
ADC_CLK  output  1  ADC sample clock, equal to ~Clk (ADC output settles mid-period)
Start  input  1  one-cycle request to begin a measurement
Busy  output  1  high while a measurement is in progress
Done  output  1  one-cycle pulse when results update
Freq_cnt  output  32  rising crossings counted in the last gate
Vmax  output  DATA_W  maximum sample in the last gate
Vmin  output  DATA_W  minimum sample in the last gate
Vpp  output  DATA_W  Vmax - Vmin of the last gate

Behaviour:
- Reset: Clock is Clk; reset is synchronous, active-low, on Reset_n. While Reset_n=0 at a Clk edge:
  - FSM goes to IDLE.
  - Busy=0, Done=0, Freq_cnt=0, Vmax=0, Vmin=0, Vpp=0.
  - Input pipeline is cleared to 0.
- Reset mid-measurement aborts the measurement; no Done is issued and outputs return to reset values.
- Input path: ADC_Data is registered twice (s1, s2). All logic below uses s2, so input latency is 2 cycles.
- Hysteresis comparator: 1-bit level L.
  - L goes 0→1 when s2 > MID+HYST; this is a rising crossing and produces a one-cycle `rise` pulse.
  - L goes 1→0 when s2 < MID-HYST.
  - Otherwise L holds its value.
- FSM states: IDLE, MEASURE, DONE.
- IDLE:
  - Busy=0.
  - Start=1 moves to MEASURE on the next cycle.
  - On that transition: gate counter=0, edge counter=0, min tracker = all ones, max tracker = 0, and L is loaded with (s2 >= MID). The initial level therefore produces no spurious edge.
- MEASURE:
  - Busy=1.
  - Each cycle updates the min and max trackers with s2.
  - Each `rise` increments the edge counter; the counter saturates at 32'hFFFF_FFFF.
  - The gate counter increments every cycle.
  - When the gate counter = GATE_CYCLES-1, the trackers take that cycle's sample and the FSM moves to DONE. MEASURE therefore lasts exactly GATE_CYCLES cycles.
- DONE (one cycle):
  - Freq_cnt, Vmax, Vmin and Vpp are registered from the counter and trackers (Vpp = max - min, unsigned, never negative since max >= min).
  - Done=1 for this cycle, Busy=0, then the FSM returns to IDLE.
  - Results are visible in the same cycle Done is high and hold until the next DONE or reset.
- Start timing:
  - Start while in MEASURE or DONE is ignored, not queued.
  - Start in the IDLE cycle immediately after DONE is accepted.
- Pipeline boundary: samples still in the input pipeline when the gate closes are not counted. A crossing is counted only if `rise` is asserted while the FSM is in MEASURE.
- Constant input: a signal that never leaves the hysteresis band gives Freq_cnt=0.
- Full-scale edges: inputs 0 and 4095 are legal; they give Vmin=0 and Vmax=4095.

Decomposition:
- Package adc_meter_pkg:
  - state enum {IDLE, MEASURE, DONE}
  - default constants DATA_W, MID, HYST, GATE_CYCLES
- One sub-module, adc_hyst_cmp:
  - Inputs: sample, init_load, init_level.
  - Outputs: level, rise.
  - Contains the hysteresis register and edge pulse.
- The FSM, gate/edge counters and min/max trackers stay in adc_freq_meter.

Test Plan (GATE_CYCLES=1000 for simulation unless noted):
- Square wave alternating 1000/3000 with a 100-cycle period, Start pulsed once → Done exactly 1001 cycles after Start; Freq_cnt=10, Vmax=3000, Vmin=1000, Vpp=2000.
- Constant input 2100 (inside band 1984..2112), Start → Freq_cnt=0, Vmax=Vmin=2100, Vpp=0.
- Square 0/4095 with a 2-cycle period plus noise of ±50 around each level → Freq_cnt=500; Vmin=0 and Vmax=4095 at full-scale samples.
- Input held at 4000 when Start fires, then dropped to 100 at cycle 500 and returned to 4000 at cycle 600 → no edge from the initial level; Freq_cnt=1.
- Start pulsed again at measurement cycle 300 → ignored; exactly one Done. Start in the cycle after Done → a second measurement begins.
- Reset_n=0 for one cycle at measurement cycle 400 → next edge gives Busy=0 and all outputs 0; no Done; a subsequent Start runs a full 1000-cycle gate.
